oric_mem_arbiter: RTL and testbench

ORIC_MEM_ARBITER -- requirements
Module: oric_mem_arbiter

---
 rtl/oric_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 tb/tb_oric_mem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/oric_mem_arbiter.sv
// Arbitrates ROM download, CPU RAM and CPU ROM byte accesses onto one toggle-handshake SDRAM port.
// Latency: request detection to mem_req toggle 1 cycle; ack match to rdata/valid 1 cycle.
// Backpressure: one SDRAM cycle in flight, one pending slot per requester (newer overwrites older).
// Optional: MEM_ARB_ROMCACHE_EN adds a one-word ROM read cache.
module oric_mem_arbiter #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        dl_en,
    input  logic        dl_wr,
    input  logic [16:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        ram_cs,
    input  logic        ram_oe,
    input  logic        ram_we,
    input  logic [15:0] ram_addr,
    input  logic [7:0]  ram_wdata,
    output logic [7:0]  ram_rdata,
    output logic        ram_valid,
    input  logic        rom_cs,
    input  logic        rom_ext_cs,
    input  logic        rom_sel,
    input  logic [15:0] rom_addr,
    output logic [7:0]  rom_rdata,
    output logic        rom_valid,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [15:0] mem_a,
    output logic [1:0]  mem_ds,
    output logic        mem_we,
    output logic [15:0] mem_d,
    input  logic [15:0] mem_q,
    output logic        busy,
    output logic        err
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HALT} state_t;
    typedef enum logic [1:0] {SRC_DL, SRC_RAM, SRC_ROM} src_t;

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TIMEOUT - 1);

    state_t        state, state_nxt;
    src_t          cur_src, gnt_src;
    logic          cur_b0;
    logic [CW-1:0] wait_cnt;

    logic          ram_rd_q, ram_wr_q, rom_cs_q, rom_ext_q;
    logic [15:0]   ram_addr_q, rom_addr_q;

    logic          dl_pend, ram_pend, rom_pend;
    logic [16:0]   dl_addr_p, ram_addr_p, rom_addr_p;
    logic [7:0]    dl_data_p, ram_data_p;
    logic          ram_we_p;

    logic          grant, grant_dl, grant_ram, grant_rom, ack_done, tmo;
    logic [16:0]   gnt_addr;
    logic [7:0]    gnt_data;
    logic          gnt_we;
    logic          rom_hit;
    logic [7:0]    hit_byte;

    // Request detection: rising selects, or address change while a read select is held.
    logic ram_rd, ram_wr, ram_wr_rise, ram_det, rom_det, dl_det;
    logic [16:0] rom_map;
    assign ram_rd      = ram_cs & ram_oe;
    assign ram_wr      = ram_cs & ram_we;
    assign ram_wr_rise = ram_wr & ~ram_wr_q;
    assign ram_det = ~dl_en & ((ram_rd & ~ram_rd_q) | ram_wr_rise |
                               (ram_rd & (ram_addr != ram_addr_q)));
    assign rom_det = ~dl_en & ((rom_cs & ~rom_cs_q) | (rom_ext_cs & ~rom_ext_q) |
                               ((rom_cs | rom_ext_cs) & (rom_addr != rom_addr_q)));
    assign dl_det  = dl_en & dl_wr;
    assign rom_map = rom_ext_cs ? {4'b0100, rom_addr[12:0]} : {1'b0, rom_sel, rom_addr[13:0]};

    // A fresh detection bypasses its slot so it can be granted in the detection cycle.
    logic        dl_vld_e, ram_vld_e, rom_vld_e, ram_we_e;
    logic [16:0] dl_addr_e, ram_addr_e, rom_addr_e;
    logic [7:0]  dl_data_e, ram_data_e;
    assign dl_vld_e   = dl_pend | dl_det;
    assign dl_addr_e  = dl_det ? dl_addr : dl_addr_p;
    assign dl_data_e  = dl_det ? dl_data : dl_data_p;
    assign ram_vld_e  = ~dl_en & (ram_pend | ram_det);
    assign ram_addr_e = ram_det ? {1'b1, ram_addr} : ram_addr_p;
    assign ram_data_e = ram_det ? ram_wdata : ram_data_p;
    assign ram_we_e   = ram_det ? ram_wr_rise : ram_we_p;
    assign rom_vld_e  = ~dl_en & ~rom_hit & (rom_pend | rom_det);
    assign rom_addr_e = rom_det ? rom_map : rom_addr_p;

    assign busy = (state != S_IDLE) | dl_pend | ram_pend | rom_pend;

`ifdef MEM_ARB_ROMCACHE_EN
    logic        cache_vld;
    logic [15:0] cache_tag, cache_dat;
    assign rom_hit  = rom_det & cache_vld & (cache_tag == rom_map[16:1]);
    assign hit_byte = rom_map[0] ? cache_dat[15:8] : cache_dat[7:0];

    // Cache fills on every ROM read completion; any download write drops it.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cache_vld <= 1'b0;
            cache_tag <= '0;
            cache_dat <= '0;
        end else begin
            if (ack_done && !mem_we && cur_src == SRC_ROM) begin
                cache_vld <= 1'b1;
                cache_tag <= mem_a;
                cache_dat <= mem_q;
            end
            if (dl_det) cache_vld <= 1'b0;
        end
    end
`else
    assign rom_hit  = 1'b0;
    assign hit_byte = 8'h00;
`endif

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next state, fixed-priority grant (download > RAM > ROM), completion and timeout.
    always_comb begin
        state_nxt = state;
        grant_dl  = 1'b0;
        grant_ram = 1'b0;
        grant_rom = 1'b0;
        ack_done  = 1'b0;
        tmo       = 1'b0;
        gnt_src   = SRC_DL;
        gnt_addr  = dl_addr_e;
        gnt_data  = dl_data_e;
        gnt_we    = 1'b1;
        case (state)
            S_IDLE: begin
                if (dl_vld_e) begin
                    grant_dl = 1'b1;
                end else if (ram_vld_e) begin
                    grant_ram = 1'b1;
                    gnt_src   = SRC_RAM;
                    gnt_addr  = ram_addr_e;
                    gnt_data  = ram_data_e;
                    gnt_we    = ram_we_e;
                end else if (rom_vld_e) begin
                    grant_rom = 1'b1;
                    gnt_src   = SRC_ROM;
                    gnt_addr  = rom_addr_e;
                    gnt_data  = 8'h00;
                    gnt_we    = 1'b0;
                end
                if (grant_dl | grant_ram | grant_rom) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ack == mem_req) begin
                    ack_done  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (wait_cnt == TMO_LAST) begin
                    tmo       = 1'b1;
                    state_nxt = S_HALT;
                end
            end
            default: state_nxt = S_HALT;
        endcase
    end
    assign grant = grant_dl | grant_ram | grant_rom;

    // Edge history and per-requester pending slots.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ram_rd_q   <= 1'b0;
            ram_wr_q   <= 1'b0;
            rom_cs_q   <= 1'b0;
            rom_ext_q  <= 1'b0;
            ram_addr_q <= '0;
            rom_addr_q <= '0;
            dl_pend    <= 1'b0;
            ram_pend   <= 1'b0;
            rom_pend   <= 1'b0;
            dl_addr_p  <= '0;
            dl_data_p  <= '0;
            ram_addr_p <= '0;
            ram_data_p <= '0;
            ram_we_p   <= 1'b0;
            rom_addr_p <= '0;
        end else begin
            ram_rd_q   <= ram_rd;
            ram_wr_q   <= ram_wr;
            rom_cs_q   <= rom_cs;
            rom_ext_q  <= rom_ext_cs;
            ram_addr_q <= ram_addr;
            rom_addr_q <= rom_addr;
            dl_pend    <= dl_vld_e & ~grant_dl;
            ram_pend   <= ram_vld_e & ~grant_ram;
            rom_pend   <= rom_vld_e & ~grant_rom;
            dl_addr_p  <= dl_addr_e;
            dl_data_p  <= dl_data_e;
            ram_addr_p <= ram_addr_e;
            ram_data_p <= ram_data_e;
            ram_we_p   <= ram_we_e;
            rom_addr_p <= rom_addr_e;
        end
    end

    // SDRAM command registers, wait counter, read-data return and sticky error.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mem_req   <= 1'b0;
            mem_a     <= '0;
            mem_ds    <= '0;
            mem_we    <= 1'b0;
            mem_d     <= '0;
            cur_src   <= SRC_DL;
            cur_b0    <= 1'b0;
            wait_cnt  <= '0;
            ram_rdata <= '0;
            ram_valid <= 1'b0;
            rom_rdata <= '0;
            rom_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            ram_valid <= 1'b0;
            rom_valid <= 1'b0;
            if (grant) begin
                mem_req  <= ~mem_req;
                mem_a    <= gnt_addr[16:1];
                mem_we   <= gnt_we;
                mem_d    <= {gnt_data, gnt_data};
                mem_ds   <= gnt_we ? (gnt_addr[0] ? 2'b10 : 2'b01) : 2'b11;
                cur_src  <= gnt_src;
                cur_b0   <= gnt_addr[0];
                wait_cnt <= '0;
            end else if (state == S_WAIT && !ack_done) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (ack_done && !mem_we) begin
                if (cur_src == SRC_RAM) begin
                    ram_rdata <= cur_b0 ? mem_q[15:8] : mem_q[7:0];
                    ram_valid <= 1'b1;
                end else if (cur_src == SRC_ROM) begin
                    rom_rdata <= cur_b0 ? mem_q[15:8] : mem_q[7:0];
                    rom_valid <= 1'b1;
                end
            end
            if (rom_hit) begin
                rom_rdata <= hit_byte;
                rom_valid <= 1'b1;
            end
            if (tmo) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_oric_mem_arbiter.sv
module tb_oric_mem_arbiter;
    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        dl_en, dl_wr;
    logic [16:0] dl_addr;
    logic [7:0]  dl_data;
    logic        ram_cs, ram_oe, ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
    logic        ram_valid;
    logic        rom_cs, rom_ext_cs, rom_sel;
    logic [15:0] rom_addr;
    logic [7:0]  rom_rdata;
    logic        rom_valid;
    logic        mem_req, mem_ack, mem_we;
    logic [15:0] mem_a, mem_d, mem_q;
    logic [1:0]  mem_ds;
    logic        busy, err;

    always #5 clk_sys = ~clk_sys;

    oric_mem_arbiter #(.ACK_TIMEOUT(8)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .dl_en(dl_en), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_valid(ram_valid),
        .rom_cs(rom_cs), .rom_ext_cs(rom_ext_cs), .rom_sel(rom_sel), .rom_addr(rom_addr),
        .rom_rdata(rom_rdata), .rom_valid(rom_valid),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_a(mem_a), .mem_ds(mem_ds),
        .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q),
        .busy(busy), .err(err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle_inputs;
        dl_en = 0; dl_wr = 0; ram_cs = 0; ram_oe = 0; ram_we = 0;
        rom_cs = 0; rom_ext_cs = 0;
    endtask

    localparam logic [1:0] K_DL = 2'd0, K_RR = 2'd1, K_RW = 2'd2, K_ROM = 2'd3;

    typedef struct {
        logic [1:0]  kind;
        logic        ext;
        logic        sel;
        logic [16:0] addr;
        logic [7:0]  wdat;
        logic [15:0] q;
        logic [15:0] exp_a;
        logic [1:0]  exp_ds;
        logic        exp_we;
        logic [15:0] exp_d;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs[9];
    logic req0, exp_req;

    initial begin
        vecs[0] = '{K_DL,  1'b0, 1'b0, 17'h00005, 8'hA9, 16'h0000, 16'h0002, 2'b10, 1'b1, 16'hA9A9, 8'h00};
        vecs[1] = '{K_DL,  1'b0, 1'b0, 17'h1FFFE, 8'h3C, 16'h0000, 16'hFFFF, 2'b01, 1'b1, 16'h3C3C, 8'h00};
        vecs[2] = '{K_RR,  1'b0, 1'b0, 17'h01234, 8'h00, 16'h5A3C, 16'h891A, 2'b11, 1'b0, 16'h0000, 8'h3C};
        vecs[3] = '{K_RR,  1'b0, 1'b0, 17'h0BFFF, 8'h00, 16'h9F00, 16'hDFFF, 2'b11, 1'b0, 16'h0000, 8'h9F};
        vecs[4] = '{K_RW,  1'b0, 1'b0, 17'h00101, 8'h66, 16'h0000, 16'h8080, 2'b10, 1'b1, 16'h6666, 8'h00};
        vecs[5] = '{K_RW,  1'b0, 1'b0, 17'h02000, 8'h81, 16'h0000, 16'h9000, 2'b01, 1'b1, 16'h8181, 8'h00};
        vecs[6] = '{K_ROM, 1'b0, 1'b0, 17'h0FFFF, 8'h00, 16'hC3A5, 16'h1FFF, 2'b11, 1'b0, 16'h0000, 8'hC3};
        vecs[7] = '{K_ROM, 1'b0, 1'b1, 17'h00020, 8'h00, 16'h1234, 16'h2010, 2'b11, 1'b0, 16'h0000, 8'h34};
        vecs[8] = '{K_ROM, 1'b1, 1'b1, 17'h0FABC, 8'h00, 16'h77EE, 16'h4D5E, 2'b11, 1'b0, 16'h0000, 8'hEE};

        reset_n = 0; idle_inputs();
        dl_addr = '0; dl_data = '0; ram_addr = '0; ram_wdata = '0;
        rom_sel = 0; rom_addr = '0; mem_ack = 0; mem_q = '0;
        tick; tick;
        chk("rst_mem", {mem_req, mem_we, mem_ds, mem_a, mem_d}, 64'h0);
        chk("rst_out", {ram_rdata, rom_rdata, ram_valid, rom_valid, busy, err}, 64'h0);
        reset_n = 1;
        tick;

        // Table-driven single transactions.
        for (int i = 0; i < 9; i++) begin
            req0 = mem_req;
            exp_req = ~req0;
            case (vecs[i].kind)
                K_DL:  begin dl_en = 1; dl_wr = 1; dl_addr = vecs[i].addr; dl_data = vecs[i].wdat; end
                K_RR:  begin ram_cs = 1; ram_oe = 1; ram_addr = vecs[i].addr[15:0]; end
                K_RW:  begin ram_cs = 1; ram_we = 1; ram_addr = vecs[i].addr[15:0]; ram_wdata = vecs[i].wdat; end
                default: begin
                    rom_sel = vecs[i].sel; rom_addr = vecs[i].addr[15:0];
                    if (vecs[i].ext) rom_ext_cs = 1; else rom_cs = 1;
                end
            endcase
            tick;
            dl_wr = 0;
            chk($sformatf("v%0d_req", i), mem_req, exp_req);
            chk($sformatf("v%0d_a", i), mem_a, vecs[i].exp_a);
            chk($sformatf("v%0d_ds", i), mem_ds, vecs[i].exp_ds);
            chk($sformatf("v%0d_we", i), mem_we, vecs[i].exp_we);
            if (vecs[i].exp_we) chk($sformatf("v%0d_d", i), mem_d, vecs[i].exp_d);
            tick; tick;
            chk($sformatf("v%0d_hold", i), {busy, mem_req, mem_a}, {1'b1, exp_req, vecs[i].exp_a});
            mem_q = vecs[i].q; mem_ack = mem_req;
            tick;
            if (vecs[i].kind == K_RR)
                chk($sformatf("v%0d_ram_rd", i), {ram_valid, rom_valid, ram_rdata}, {1'b1, 1'b0, vecs[i].exp_rd});
            else if (vecs[i].kind == K_ROM)
                chk($sformatf("v%0d_rom_rd", i), {ram_valid, rom_valid, rom_rdata}, {1'b0, 1'b1, vecs[i].exp_rd});
            else
                chk($sformatf("v%0d_novalid", i), {ram_valid, rom_valid}, 2'b00);
            tick;
            chk($sformatf("v%0d_done", i), {ram_valid, rom_valid, busy}, 3'b000);
            idle_inputs();
            tick;
        end

        // RAM and ROM detected together: RAM first, ROM right after RAM completes.
        req0 = mem_req; exp_req = ~req0;
        ram_cs = 1; ram_oe = 1; ram_addr = 16'h0042;
        rom_cs = 1; rom_sel = 1; rom_addr = 16'h0100;
        tick;
        chk("pri_ram_a", {mem_req, mem_a}, {exp_req, 16'h8021});
        repeat (4) tick;
        chk("pri_ram_hold", {busy, mem_req, mem_a}, {1'b1, exp_req, 16'h8021});
        mem_q = 16'hBEEF; mem_ack = mem_req;
        tick;
        chk("pri_ram_rd", {ram_valid, ram_rdata, mem_req}, {1'b1, 8'hEF, exp_req});
        tick;
        chk("pri_rom_gnt", {mem_req, mem_a, mem_ds, ram_valid}, {req0, 16'h2080, 2'b11, 1'b0});
        mem_q = 16'h1122; mem_ack = mem_req;
        tick;
        chk("pri_rom_rd", {rom_valid, rom_rdata}, {1'b1, 8'h22});
        idle_inputs();
        tick;

        // RAM detection ignored while a download is active.
        req0 = mem_req;
        dl_en = 1; ram_cs = 1; ram_oe = 1; ram_addr = 16'h0050;
        tick; tick;
        chk("dl_blocks_ram", {mem_req, busy}, {req0, 1'b0});
        ram_cs = 0; ram_oe = 0;
        tick;
        idle_inputs();
        tick;

        // Two bytes of the same ROM word.
        req0 = mem_req; exp_req = ~req0;
        rom_cs = 1; rom_sel = 1; rom_addr = 16'h0010;
        tick;
        chk("rc_first_gnt", {mem_req, mem_a}, {exp_req, 16'h2008});
        mem_q = 16'hA55A; mem_ack = mem_req;
        tick;
        chk("rc_first_rd", {rom_valid, rom_rdata}, {1'b1, 8'h5A});
        rom_addr = 16'h0011;
        tick;
`ifdef MEM_ARB_ROMCACHE_EN
        chk("rc_hit", {mem_req, rom_valid, rom_rdata}, {exp_req, 1'b1, 8'hA5});
        tick;
        chk("rc_idle", {busy, rom_valid}, 2'b00);
`else
        chk("rc_second_gnt", {mem_req, mem_a}, {req0, 16'h2008});
        mem_ack = mem_req;
        tick;
        chk("rc_second_rd", {rom_valid, rom_rdata}, {1'b1, 8'hA5});
`endif
        idle_inputs();
        tick;

        // Reset in the middle of WAIT.
        req0 = mem_req; exp_req = ~req0;
        ram_cs = 1; ram_oe = 1; ram_addr = 16'h0300;
        tick;
        chk("rw_gnt", {mem_req, mem_a}, {exp_req, 16'h8180});
        tick; tick;
        reset_n = 0;
        #1;
        chk("rw_rst_mem", {mem_req, mem_we, mem_ds, mem_a, mem_d}, 64'h0);
        chk("rw_rst_out", {ram_rdata, rom_rdata, ram_valid, rom_valid, busy, err}, 64'h0);
        idle_inputs(); mem_ack = 0;
        tick;
        reset_n = 1;
        tick;
        ram_cs = 1; ram_oe = 1; ram_addr = 16'h0301;
        tick;
        chk("rw_post_gnt", {mem_req, mem_a, mem_ds}, {1'b1, 16'h8180, 2'b11});
        mem_q = 16'hAB00; mem_ack = mem_req;
        tick;
        chk("rw_post_rd", {ram_valid, ram_rdata}, {1'b1, 8'hAB});
        idle_inputs();
        tick;

        // Ack never arrives: error after 8 WAIT cycles, then no more grants.
        req0 = mem_req; exp_req = ~req0;
        ram_cs = 1; ram_oe = 1; ram_addr = 16'h0400;
        tick;
        chk("to_gnt", mem_req, exp_req);
        repeat (7) tick;
        chk("to_err_early", err, 1'b0);
        tick;
        chk("to_err_set", err, 1'b1);
        idle_inputs();
        tick;
        rom_cs = 1; rom_sel = 0; rom_addr = 16'h0500;
        repeat (4) tick;
        chk("to_halt", {mem_req, busy, err}, {exp_req, 1'b1, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
